// File: rtl/bridge_pkg.sv
// Shared constants for the CPU-to-device bridge and its interrupt controller.
// Register offsets are byte offsets from the controller base address.
package bridge_pkg;
    localparam logic [31:0] OFF_PEND = 32'h0000_0000;
    localparam logic [31:0] OFF_MASK = 32'h0000_0004;
    localparam logic [31:0] OFF_CUR  = 32'h0000_0008;
    localparam logic [31:0] OFF_STAT = 32'h0000_0010;
    localparam logic [31:0] CUR_NONE = 32'hFFFF_FFFF;
    localparam int          HWINT_W  = 6;

    // Word-granular address match; byte-lane bits are ignored.
    function automatic logic word_eq(input logic [31:0] a, input logic [31:0] b);
        return a[31:2] == b[31:2];
    endfunction
endpackage

// File: rtl/pic_src.sv
// One interrupt source: edge capture of the device IRQ level into a sticky pending bit.
// Optional saturating rise-event counter when PIC_STATS_EN is defined.
module pic_src (
    input  logic        clk,
    input  logic        reset,
    input  logic        irq,
    input  logic        w1c,
`ifdef PIC_STATS_EN
    input  logic        stat_clr,
    output logic [15:0] stat,
`endif
    output logic        pend
);
    logic irq_q, irq_d;
    logic pend_q, pend_d;
    logic rise;

    // A new rise beats a same-cycle clear so no event is ever lost.
    always_comb begin
        rise   = irq & ~irq_q;
        irq_d  = irq;
        pend_d = (pend_q & ~w1c) | rise;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            irq_q  <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            irq_q  <= irq_d;
            pend_q <= pend_d;
        end
    end

    assign pend = pend_q;

`ifdef PIC_STATS_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (stat_clr)
            cnt_d = '0;
        else if (rise && cnt_q != 16'hFFFF)
            cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign stat = cnt_q;
`endif
endmodule

// File: rtl/dev_bridge_pic.sv
// CPU bridge to NDEV memory-mapped devices with an integrated masked interrupt controller.
// Define PIC_STATS_EN to add per-source rise-event counters at PIC+0x10+4*i.
module dev_bridge_pic
    import bridge_pkg::*;
#(
    parameter int unsigned NDEV = 3,
    parameter logic [31:0] BASE = 32'h7F00,
    parameter logic [31:0] PIC  = 32'h7F40
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          cpu_addr,
    input  logic                 cpu_we,
    input  logic [31:0]          cpu_din,
    output logic [31:0]          cpu_dout,
    output logic                 cpu_miss,
    output logic [7:0]           dev_addr,
    output logic [31:0]          dev_din,
    output logic [NDEV-1:0]      dev_we,
    input  logic [32*NDEV-1:0]   dev_dout,
    input  logic [NDEV-1:0]      dev_irq,
    output logic [HWINT_W-1:0]   hw_int
);
    logic [NDEV-1:0]    hit;
    logic [NDEV-1:0]    stat_hit;
    logic [NDEV-1:0]    pend;
    logic [NDEV-1:0]    w1c;
    logic [NDEV-1:0]    mask_q, mask_d;
    logic [HWINT_W-1:0] hw_int_q, hw_int_d;
    logic               pic_hit, in_range, pic_we;
    logic [31:0]        cur;
`ifdef PIC_STATS_EN
    logic [NDEV-1:0]    stat_clr;
    logic [15:0]        stat [NDEV];
`endif

    always_comb begin
        hit      = '0;
        stat_hit = '0;
        for (int i = 0; i < NDEV; i++) begin
            hit[i] = cpu_addr[31:4] == ((BASE + (32'(i) << 4)) >> 4);
`ifdef PIC_STATS_EN
            stat_hit[i] = word_eq(cpu_addr, PIC + OFF_STAT + (32'(i) << 2));
`endif
        end
        pic_hit  = cpu_addr[31:4] == PIC[31:4];
        in_range = (cpu_addr >= BASE) && (cpu_addr <= BASE + 32'h0000_00FF);
        cpu_miss = in_range & ~(|hit | pic_hit | |stat_hit);
        // Stores are suppressed while reset is asserted so devices see no strobe.
        dev_we   = {NDEV{cpu_we & reset}} & hit;
        pic_we   = cpu_we & reset & pic_hit;
    end

    assign dev_addr = cpu_addr[7:0];
    assign dev_din  = cpu_din;

    always_comb begin
        cur = CUR_NONE;
        for (int i = NDEV - 1; i >= 0; i--)
            if (pend[i] & mask_q[i]) cur = 32'(i);
    end

    always_comb begin
        w1c      = '0;
        mask_d   = mask_q;
        hw_int_d = '0;
        if (pic_we && word_eq(cpu_addr, PIC + OFF_PEND)) w1c    = cpu_din[NDEV-1:0];
        if (pic_we && word_eq(cpu_addr, PIC + OFF_MASK)) mask_d = cpu_din[NDEV-1:0];
        hw_int_d[NDEV-1:0] = pend & mask_q;
    end

    always_comb begin
        cpu_dout = '0;
        for (int i = 0; i < NDEV; i++) begin
            if (hit[i]) cpu_dout = dev_dout[32*i +: 32];
`ifdef PIC_STATS_EN
            if (stat_hit[i]) cpu_dout = 32'(stat[i]);
`endif
        end
        if (pic_hit) begin
            if (word_eq(cpu_addr, PIC + OFF_PEND)) cpu_dout = 32'(pend);
            if (word_eq(cpu_addr, PIC + OFF_MASK)) cpu_dout = 32'(mask_q);
            if (word_eq(cpu_addr, PIC + OFF_CUR))  cpu_dout = cur;
        end
    end

`ifdef PIC_STATS_EN
    assign stat_clr = {NDEV{cpu_we & reset}} & stat_hit;
`endif

    for (genvar g = 0; g < NDEV; g++) begin : g_src
        pic_src u_src (
            .clk      (clk),
            .reset    (reset),
            .irq      (dev_irq[g]),
            .w1c      (w1c[g]),
`ifdef PIC_STATS_EN
            .stat_clr (stat_clr[g]),
            .stat     (stat[g]),
`endif
            .pend     (pend[g])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mask_q   <= '0;
            hw_int_q <= '0;
        end else begin
            mask_q   <= mask_d;
            hw_int_q <= hw_int_d;
        end
    end

    assign hw_int = hw_int_q;
endmodule
